// File: rtl/actuator_slot_scheduler.sv
// actuator_slot_scheduler
// Round-robin, power-budgeted scheduler for the six wearable actuators.
// In budgeted mode at most MAX_ON actuators are driven per fixed-length slot,
// and grants rotate through the requesters slot by slot. Severe dehydration
// bypasses the budget and drives every requested actuator directly.
module actuator_slot_scheduler #(
    parameter int MAX_ON      = 2,
    parameter int SLOT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] act_req,
    input  logic [1:0] state_code,
    output logic [5:0] act_drive,
    output logic [1:0] sched_state,
    output logic       slot_start,
    output logic [2:0] active_count
);

    localparam int                CNT_W    = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [2:0]        MAX_ON_W = 3'(MAX_ON);
    localparam logic [1:0]        SEVERE   = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SLICE    = 2'b01,
        OVERRIDE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [5:0]       drive_d;
    logic             start_d;
    logic [2:0]       count_d;

    // Selection scratch: grant vector and the pointer that follows it.
    logic [5:0]       sel_grant;
    logic [2:0]       sel_ptr;
    logic [2:0]       sel_cnt;
    logic [3:0]       sel_sum;
    logic [2:0]       sel_idx;

    assign sched_state = state_q;

    // Round-robin selection: walk the six indices starting at ptr_q and grant
    // the first MAX_ON requesters; the next slot starts just after the last grant.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        sel_grant = '0;
        sel_ptr   = ptr_q;
        sel_cnt   = '0;
        sel_sum   = '0;
        sel_idx   = '0;
        for (int k = 0; k < 6; k++) begin
            sel_sum = {1'b0, ptr_q} + 4'(k);
            sel_idx = (sel_sum >= 4'd6) ? 3'(sel_sum - 4'd6) : sel_sum[2:0];
            if (act_req[sel_idx] && (sel_cnt < MAX_ON_W)) begin
                sel_grant[sel_idx] = 1'b1;
                sel_cnt            = sel_cnt + 3'd1;
                sel_ptr            = (sel_idx == 3'd5) ? 3'd0 : sel_idx + 3'd1;
            end
        end
    end

    // Next-state logic, highest priority first: exit to IDLE, override,
    // new slot (entry or boundary), then mid-slot masking of dropped requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        drive_d = act_drive;
        start_d = 1'b0;
        if (!enable || (act_req == 6'b0)) begin
            state_d = IDLE;
            cnt_d   = '0;
            drive_d = '0;
        end else if (state_code == SEVERE) begin
            state_d = OVERRIDE;
            cnt_d   = '0;
            drive_d = act_req;
        end else if ((state_q != SLICE) || (cnt_q == CNT_LAST)) begin
            state_d = SLICE;
            cnt_d   = '0;
            drive_d = sel_grant;
            ptr_d   = sel_ptr;
            start_d = 1'b1;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            drive_d = act_drive & act_req;
        end
    end

    // Popcount of the drive vector being loaded, so active_count tracks it exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < 6; i++) begin
            count_d = count_d + {2'b0, drive_d[i]};
        end
    end

    // State, slot counter, rr pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            act_drive    <= '0;
            slot_start   <= 1'b0;
            active_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            act_drive    <= drive_d;
            slot_start   <= start_d;
            active_count <= count_d;
        end
    end

endmodule

// File: tb/tb_actuator_slot_scheduler.sv
// Directed testbench for actuator_slot_scheduler (MAX_ON=2, SLOT_CYCLES=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_actuator_slot_scheduler;

    localparam int MAX_ON      = 2;
    localparam int SLOT_CYCLES = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       enable     = 1'b0;
    logic [5:0] act_req    = 6'b0;
    logic [1:0] state_code = 2'b01;
    logic [5:0] act_drive;
    logic [1:0] sched_state;
    logic       slot_start;
    logic [2:0] active_count;

    int checks   = 0;
    int failures = 0;

    actuator_slot_scheduler #(
        .MAX_ON      (MAX_ON),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .act_req      (act_req),
        .state_code   (state_code),
        .act_drive    (act_drive),
        .sched_state  (sched_state),
        .slot_start   (slot_start),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst_n      = 1'b0;
        enable     = 1'b0;
        act_req    = 6'b0;
        state_code = 2'b01;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        enable     = 1'b1;
        act_req    = 6'b111111;
        state_code = 2'b01;
        tick();
        tick();
        checks++; if (act_drive !== 6'b0) begin failures++; $display("FAIL reset_drive: got %b want %b", act_drive, 6'b0); end
        checks++; if (sched_state !== 2'b00) begin failures++; $display("FAIL reset_state: got %b want %b", sched_state, 2'b00); end
        checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL reset_slot_start: got %b want 0", slot_start); end
        checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", active_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (act_drive !== 6'b000011) begin failures++; $display("FAIL first_sel_drive: got %b want %b", act_drive, 6'b000011); end
        checks++; if (sched_state !== 2'b01) begin failures++; $display("FAIL first_sel_state: got %b want %b", sched_state, 2'b01); end
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL first_sel_start: got %b want 1", slot_start); end
        checks++; if (active_count !== 3'd2) begin failures++; $display("FAIL first_sel_count: got %0d want 2", active_count); end
    endtask

    task automatic test_round_robin;
        logic [5:0] exp_drive;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b101101;
        for (int c = 0; c < 24; c++) begin
            tick();
            exp_drive = (((c / 8) % 2) == 0) ? 6'b000101 : 6'b101000;
            checks++; if (act_drive !== exp_drive) begin failures++; $display("FAIL rr_drive c=%0d: got %b want %b", c, act_drive, exp_drive); end
            checks++; if (slot_start !== ((c % 8) == 0)) begin failures++; $display("FAIL rr_start c=%0d: got %b want %b", c, slot_start, ((c % 8) == 0)); end
            checks++; if (active_count !== 3'd2) begin failures++; $display("FAIL rr_count c=%0d: got %0d want 2", c, active_count); end
            checks++; if (sched_state !== 2'b01) begin failures++; $display("FAIL rr_state c=%0d: got %b want 01", c, sched_state); end
        end
    endtask

    task automatic test_wrap;
        logic [5:0] pat [3];
        logic [5:0] exp_drive;
        pat[0] = 6'b000011;
        pat[1] = 6'b100001;
        pat[2] = 6'b100010;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b100011;
        for (int c = 0; c < 32; c++) begin
            tick();
            exp_drive = pat[(c / 8) % 3];
            checks++; if (act_drive !== exp_drive) begin failures++; $display("FAIL wrap_drive c=%0d: got %b want %b", c, act_drive, exp_drive); end
            checks++; if (slot_start !== ((c % 8) == 0)) begin failures++; $display("FAIL wrap_start c=%0d: got %b want %b", c, slot_start, ((c % 8) == 0)); end
        end
    endtask

    task automatic test_mid_drop;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b101101;
        tick();  // slot cycle 0: 000101, ptr -> 3
        tick();
        tick();
        act_req = 6'b101001;  // drop bit 2
        for (int c = 3; c < 8; c++) begin
            tick();
            checks++; if (act_drive !== 6'b000001) begin failures++; $display("FAIL drop_drive c=%0d: got %b want %b", c, act_drive, 6'b000001); end
            checks++; if (active_count !== 3'd1) begin failures++; $display("FAIL drop_count c=%0d: got %0d want 1", c, active_count); end
            checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL drop_start c=%0d: got %b want 0", c, slot_start); end
        end
        tick();  // boundary: SEL(101001, ptr=3) -> bits 3,5
        checks++; if (act_drive !== 6'b101000) begin failures++; $display("FAIL drop_boundary_drive: got %b want %b", act_drive, 6'b101000); end
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL drop_boundary_start: got %b want 1", slot_start); end
    endtask

    task automatic test_override;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b101101;
        tick();  // 000101, ptr -> 3
        tick();
        tick();
        state_code = 2'b10;
        act_req    = 6'b111111;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (act_drive !== 6'b111111) begin failures++; $display("FAIL ovr_drive c=%0d: got %b want %b", c, act_drive, 6'b111111); end
            checks++; if (sched_state !== 2'b10) begin failures++; $display("FAIL ovr_state c=%0d: got %b want 10", c, sched_state); end
            checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL ovr_start c=%0d: got %b want 0", c, slot_start); end
            checks++; if (active_count !== 3'd6) begin failures++; $display("FAIL ovr_count c=%0d: got %0d want 6", c, active_count); end
        end
        state_code = 2'b01;
        tick();  // fresh slot: SEL(111111, ptr=3) -> bits 3,4
        checks++; if (act_drive !== 6'b011000) begin failures++; $display("FAIL ovr_exit_drive: got %b want %b", act_drive, 6'b011000); end
        checks++; if (sched_state !== 2'b01) begin failures++; $display("FAIL ovr_exit_state: got %b want 01", sched_state); end
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL ovr_exit_start: got %b want 1", slot_start); end
        checks++; if (active_count !== 3'd2) begin failures++; $display("FAIL ovr_exit_count: got %0d want 2", active_count); end
        tick();
        checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL ovr_exit_pulse_width: got %b want 0", slot_start); end
        checks++; if (act_drive !== 6'b011000) begin failures++; $display("FAIL ovr_exit_hold: got %b want %b", act_drive, 6'b011000); end
    endtask

    task automatic test_override_from_idle;
        apply_reset();
        enable     = 1'b1;
        state_code = 2'b10;
        act_req    = 6'b010110;
        tick();
        checks++; if (act_drive !== 6'b010110) begin failures++; $display("FAIL idle_ovr_drive: got %b want %b", act_drive, 6'b010110); end
        checks++; if (sched_state !== 2'b10) begin failures++; $display("FAIL idle_ovr_state: got %b want 10", sched_state); end
        checks++; if (active_count !== 3'd3) begin failures++; $display("FAIL idle_ovr_count: got %0d want 3", active_count); end
        checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL idle_ovr_start: got %b want 0", slot_start); end
    endtask

    task automatic test_enable_exit;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b101101;
        tick();  // 000101, ptr -> 3
        tick();
        enable = 1'b0;
        tick();
        checks++; if (sched_state !== 2'b00) begin failures++; $display("FAIL dis_state: got %b want 00", sched_state); end
        checks++; if (act_drive !== 6'b0) begin failures++; $display("FAIL dis_drive: got %b want %b", act_drive, 6'b0); end
        checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL dis_count: got %0d want 0", active_count); end
        checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL dis_start: got %b want 0", slot_start); end
        enable = 1'b1;
        tick();  // retained ptr=3 -> bits 3,5
        checks++; if (act_drive !== 6'b101000) begin failures++; $display("FAIL reen_drive: got %b want %b", act_drive, 6'b101000); end
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL reen_start: got %b want 1", slot_start); end
        act_req = 6'b0;
        tick();
        checks++; if (sched_state !== 2'b00) begin failures++; $display("FAIL noreq_state: got %b want 00", sched_state); end
        checks++; if (act_drive !== 6'b0) begin failures++; $display("FAIL noreq_drive: got %b want %b", act_drive, 6'b0); end
    endtask

    task automatic test_async_reset;
        apply_reset();
        enable  = 1'b1;
        act_req = 6'b101101;
        tick();  // 000101, ptr -> 3
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (act_drive !== 6'b0) begin failures++; $display("FAIL async_drive: got %b want %b", act_drive, 6'b0); end
        checks++; if (sched_state !== 2'b00) begin failures++; $display("FAIL async_state: got %b want 00", sched_state); end
        checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL async_count: got %0d want 0", active_count); end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();  // ptr back to 0 -> bits 0,2
        checks++; if (act_drive !== 6'b000101) begin failures++; $display("FAIL async_restart_drive: got %b want %b", act_drive, 6'b000101); end
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL async_restart_start: got %b want 1", slot_start); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_wrap();
        test_mid_drop();
        test_override();
        test_override_from_idle();
        test_enable_exit();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
